// File: rtl/fpnew_result_queue.sv
// Result FIFO behind fpnew_top with a valid/ready consumer port.
// Optional sticky fflags, enabled by `define FPNEW_RESULT_QUEUE_FFLAGS_EN.
module fpnew_result_queue #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TAG_WIDTH = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         fpu_valid_i,
   output logic                         fpu_ready_o,
   input  logic [WIDTH-1:0]             fpu_result_i,
   input  logic [4:0]                   fpu_status_i,
   input  logic [TAG_WIDTH-1:0]         fpu_tag_i,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic [WIDTH-1:0]             res_data_o,
   output logic [4:0]                   res_status_o,
   output logic [TAG_WIDTH-1:0]         res_tag_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [4:0]                   fflags_o,
   input  logic                         fflags_clr_i
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = WIDTH + 5 + TAG_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic push, pop, push_acc, pop_acc;

   // Ready depends only on registered occupancy, never on res_ready_i.
   assign fpu_ready_o = (cnt_q != FULL);
   assign res_valid_o = (cnt_q != '0);
   assign count_o     = cnt_q;

   assign push     = fpu_valid_i & fpu_ready_o;
   assign pop      = res_valid_o & res_ready_i;
   assign push_acc = push & ~flush_i;
   assign pop_acc  = pop & ~flush_i;

   assign {res_data_o, res_status_o, res_tag_o} = mem_q[rptr_q];

   always_comb begin
      mem_d = mem_q;
      if (push_acc) begin
         mem_d[wptr_q] = {fpu_result_i, fpu_status_i, fpu_tag_i};
      end
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push_acc) wptr_d = wptr_q + PW'(1);
         if (pop_acc)  rptr_d = rptr_q + PW'(1);
         unique case ({push_acc, pop_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifdef FPNEW_RESULT_QUEUE_FFLAGS_EN
   logic [4:0] fflags_q, fflags_d;

   always_comb begin
      fflags_d = fflags_q;
      if (push_acc) begin
         fflags_d = fflags_clr_i ? fpu_status_i
                                 : (fflags_q | fpu_status_i);
      end else if (fflags_clr_i) begin
         fflags_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= fflags_d;
      end
   end

   assign fflags_o = fflags_q;
`else
   logic unused_fflags_clr;
   assign unused_fflags_clr = fflags_clr_i;
   assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_fpnew_result_queue.sv
// Directed self-checking bench for fpnew_result_queue.
// Flag expectations follow FPNEW_RESULT_QUEUE_FFLAGS_EN.
module tb_fpnew_result_queue;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        fpu_valid_i = 1'b0;
   logic        fpu_ready_o;
   logic [15:0] fpu_result_i = '0;
   logic [4:0]  fpu_status_i = '0;
   logic [0:0]  fpu_tag_i = '0;
   logic        res_valid_o;
   logic        res_ready_i = 1'b0;
   logic [15:0] res_data_o;
   logic [4:0]  res_status_o;
   logic [0:0]  res_tag_o;
   logic [2:0]  count_o;
   logic [4:0]  fflags_o;
   logic        fflags_clr_i = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   fpnew_result_queue #(
      .WIDTH(16), .DEPTH(4), .TAG_WIDTH(1)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
      .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
      .fpu_tag_i(fpu_tag_i), .res_valid_o(res_valid_o),
      .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .res_status_o(res_status_o), .res_tag_o(res_tag_o),
      .count_o(count_o), .fflags_o(fflags_o),
      .fflags_clr_i(fflags_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [4:0] ff(input logic [4:0] v);
`ifdef FPNEW_RESULT_QUEUE_FFLAGS_EN
      return v;
`else
      return 5'b0 & v;
`endif
   endfunction

   logic [15:0] t1 [3];
   logic [15:0] t6d [3];
   logic [0:0]  t6t [3];

   initial begin
      t1[0] = 16'h4000; t1[1] = 16'h3C00; t1[2] = 16'h7C00;
      t6d[0] = 16'h00A1; t6d[1] = 16'h00A2; t6d[2] = 16'h00A3;
      t6t[0] = 1'b1; t6t[1] = 1'b0; t6t[2] = 1'b1;

      #2;
      check("rst_count", 32'(count_o), 0);
      check("rst_valid", 32'(res_valid_o), 0);
      check("rst_ready", 32'(fpu_ready_o), 1);
      check("rst_fflags", 32'(fflags_o), 0);
      tick();
      rst_ni = 1'b1;
      tick();

      // 1: three pushes, then ordered pops
      fpu_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fpu_result_i = t1[i];
         tick();
      end
      fpu_valid_i = 1'b0;
      check("t1_count", 32'(count_o), 3);
      check("t1_head", 32'(res_data_o), 32'h4000);
      res_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t1_valid", 32'(res_valid_o), 1);
         check("t1_pop", 32'(res_data_o), 32'(t1[i]));
         tick();
      end
      check("t1_empty", 32'(res_valid_o), 0);
      res_ready_i = 1'b0;

      // 2: fill, hold fifth, one pop frees a slot
      fpu_valid_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         fpu_result_i = 16'(i);
         tick();
      end
      fpu_result_i = 16'h5;
      check("t2_full_cnt", 32'(count_o), 4);
      check("t2_full_rdy", 32'(fpu_ready_o), 0);
      tick();
      tick();
      check("t2_held_cnt", 32'(count_o), 4);
      check("t2_held_head", 32'(res_data_o), 1);
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      check("t2_pop_cnt", 32'(count_o), 3);
      check("t2_pop_rdy", 32'(fpu_ready_o), 1);
      tick();
      fpu_valid_i = 1'b0;
      check("t2_acc_cnt", 32'(count_o), 4);
      res_ready_i = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         check("t2_drain", 32'(res_data_o), i);
         tick();
      end
      check("t2_empty", 32'(count_o), 0);

      // 3: streaming with both sides always ready
      fpu_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         fpu_result_i = 16'h0100 + 16'(i);
         tick();
         check("t3_count", 32'(count_o), 1);
         check("t3_data", 32'(res_data_o), 32'h100 + i);
      end
      fpu_valid_i = 1'b0;
      tick();
      check("t3_drained", 32'(count_o), 0);

      // 4: sticky flags
      fflags_clr_i = 1'b1;
      tick();
      fflags_clr_i = 1'b0;
      check("t4_clr", 32'(fflags_o), 0);
      fpu_valid_i = 1'b1;
      fpu_status_i = 5'b10000;
      tick();
      check("t4_nv", 32'(fflags_o), 32'(ff(5'b10000)));
      fpu_status_i = 5'b00001;
      tick();
      check("t4_or", 32'(fflags_o), 32'(ff(5'b10001)));
      check("t4_rstat", 32'(res_status_o), 32'b00001);
      fpu_status_i = 5'b00100;
      fflags_clr_i = 1'b1;
      tick();
      fflags_clr_i = 1'b0;
      fpu_valid_i = 1'b0;
      check("t4_clrpush", 32'(fflags_o), 32'(ff(5'b00100)));
      tick();
      check("t4_hold", 32'(fflags_o), 32'(ff(5'b00100)));

      // 5: flush with coincident push, then async reset
      res_ready_i = 1'b0;
      fpu_valid_i = 1'b1;
      fpu_status_i = 5'b01000;
      tick();
      tick();
      check("t5_pre_cnt", 32'(count_o), 2);
      check("t5_pre_ff", 32'(fflags_o), 32'(ff(5'b01100)));
      fpu_status_i = 5'b00010;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      fpu_valid_i = 1'b0;
      check("t5_fl_cnt", 32'(count_o), 0);
      check("t5_fl_valid", 32'(res_valid_o), 0);
      check("t5_fl_ff", 32'(fflags_o), 32'(ff(5'b01100)));
      fpu_valid_i = 1'b1;
      fpu_status_i = 5'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t5_full", 32'(fpu_ready_o), 0);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t5_rst_valid", 32'(res_valid_o), 0);
      check("t5_rst_ready", 32'(fpu_ready_o), 1);
      check("t5_rst_cnt", 32'(count_o), 0);
      check("t5_rst_ff", 32'(fflags_o), 0);
      fpu_valid_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();

      // 6: tag passthrough
      fpu_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fpu_result_i = t6d[i];
         fpu_tag_i = t6t[i];
         tick();
      end
      fpu_valid_i = 1'b0;
      res_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t6_tag", 32'(res_tag_o), 32'(t6t[i]));
         check("t6_data", 32'(res_data_o), 32'(t6d[i]));
         tick();
      end
      check("t6_empty", 32'(res_valid_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fpnew_result_queue.md
# fpnew_result_queue

Output-side companion to `fpnew_top`: consumes the FPU result handshake (`out_valid_o`/`out_ready_i`, `result_o`, `status_o`, `tag_o`) and buffers results in a small FIFO. Results are presented to a downstream consumer through an independent valid/ready port. Optionally accumulates RISC-V-style sticky exception flags (fflags). It sits between `fpnew_top` and the writeback/consumer logic, and decouples FPU completion from consumer backpressure.

## Interface
Parameters:
- `WIDTH`, 16, result width; matches the FPU `Features.Width`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TAG_WIDTH`, 1, width of the tag carried with each result.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous flush of all buffered entries.
- `fpu_valid_i` in 1: FPU result valid; connect to `out_valid_o`.
- `fpu_ready_o` out 1: queue can accept; connect to FPU `out_ready_i`.
- `fpu_result_i` in `WIDTH`: FPU `result_o`.
- `fpu_status_i` in 5: FPU `status_o` as `{NV,DZ,OF,UF,NX}`, MSB to LSB.
- `fpu_tag_i` in `TAG_WIDTH`: FPU `tag_o`.
- `res_valid_o` out 1: head entry valid.
- `res_ready_i` in 1: consumer accepts head.
- `res_data_o` out `WIDTH`: head result.
- `res_status_o` out 5: head status.
- `res_tag_o` out `TAG_WIDTH`: head tag.
- `count_o` out `$clog2(DEPTH+1)`: number of occupied entries.
- `fflags_o` out 5: sticky OR of accepted statuses.
- `fflags_clr_i` in 1: clears the sticky flags.

## Operation
- Push: `fpu_valid_i && fpu_ready_o` at a rising edge writes `{result,status,tag}` at the write pointer. The write pointer increments modulo `DEPTH`.
- Pop: `res_valid_o && res_ready_i` at a rising edge advances the read pointer modulo `DEPTH`.
- Push and pop in the same cycle: `count_o` is unchanged and both pointers advance. Full throughput is sustained at any occupancy below full.
- `fpu_ready_o = (count_o != DEPTH)`. It is derived from registered state only, so there is no combinational path from `res_ready_i` to `fpu_ready_o`.
- Full: `fpu_ready_o` = 0 even if a pop occurs that cycle. The FPU holds its result, which follows the FPU handshake rule.
- `res_valid_o = (count_o != 0)`. Head fields come straight from storage (first-word-fall-through). There is no input-to-output bypass.
- When `res_valid_o` = 0, the values on `res_data_o`, `res_status_o` and `res_tag_o` are don't-care. The bench must not check them.
- Flush: at a rising edge with `flush_i` = 1, pointers and count clear to 0. Any push or pop in that cycle is discarded. `fflags_o` is not affected by flush.
- Sticky flags update at push time, not pop time:
  - `fflags_clr_i` = 0: `fflags <= fflags | pushed_status`.
  - `fflags_clr_i` = 1 with no push: `fflags <= 0`.
  - `fflags_clr_i` = 1 with a push: `fflags <= pushed_status`.
  - A push discarded by flush does not update `fflags`.

## Timing
Reset values (`rst_ni` low):
- Pointers and count are 0, so `count_o` = 0 and `res_valid_o` = 0.
- `fpu_ready_o` = 1 (as soon as reset is asserted).
- `fflags_o` = 0.
- Storage contents are not reset.

Reset asserted mid-operation drops all entries immediately and asynchronously.

Latency and throughput:
- A push at edge N appears on `res_valid_o` after edge N (1-cycle latency).
- Throughput is 1 result per cycle in and out.
- `fflags_o` reflects a push one cycle after the accepting edge.

## Configuration
- `FPNEW_RESULT_QUEUE_FFLAGS_EN` defined: the sticky flag register and `fflags_clr_i` logic are built as described above.
- Macro undefined: no flag register is synthesised, `fflags_o` is tied to 5'b0 and `fflags_clr_i` is ignored.
- FIFO behaviour and `res_status_o` are identical in both builds.

## Test plan
1. Reset, then three pushes of results 0x4000, 0x3C00, 0x7C00 with `res_ready_i` = 0:
   - `count_o` = 3 and `res_data_o` = 0x4000.
   - Then `res_ready_i` = 1 pops in order 0x4000, 0x3C00, 0x7C00 on consecutive cycles.
2. Fill to `DEPTH` = 4 with `res_ready_i` = 0:
   - `fpu_ready_o` = 0 while full, and a held fifth FPU result is not written.
   - One pop restores `fpu_ready_o` = 1 the next cycle, and the fifth result is then accepted.
3. Continuous `fpu_valid_i` = 1 and `res_ready_i` = 1 for 20 cycles with incrementing data:
   - `count_o` stays at 1 after the first cycle.
   - Output data equals input data delayed by one cycle, with no drops.
4. `FPNEW_RESULT_QUEUE_FFLAGS_EN` defined:
   - Push status 5'b10000 then 5'b00001: `fflags_o` = 5'b10001.
   - Push status 5'b00100 with `fflags_clr_i` = 1: `fflags_o` = 5'b00100.
   - Macro undefined: `fflags_o` = 0 throughout.
5. Flush and reset:
   - With 2 entries queued, `flush_i` = 1 coincident with a push: next cycle `count_o` = 0, `res_valid_o` = 0, and `fflags_o` is unchanged.
   - Assert `rst_ni` low mid-stream: `res_valid_o` = 0 and `fpu_ready_o` = 1 immediately.
6. Tag passthrough with `TAG_WIDTH` = 1: push tags 1, 0, 1 → `res_tag_o` sequence 1, 0, 1, aligned with the corresponding data.
